fsquare_iter: RTL and testbench
===============================

FSQUARE_ITER -- requirements
Module: fsquare_iter

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
 clk  input  1  single clock; all state changes on its rising edge.
 rstn  input  1  synchronous, active-low reset.
 in_valid  input  1  operand x is offered.
 in_ready  output  1  unit can accept an operand.
 x  input  32  IEEE-754 single-precision operand.
 out_valid  output  1  result y is valid.
 out_ready  input  1  consumer accepts the result.
 y  output  32  single-precision x*x.
 ovf  output  1  result overflowed to +inf.
 udf  output  1  result underflowed and was flushed to +0.
REQ-002 The module SHALL have no parameters.

Function
REQ-003 The module SHALL compute y = x*x with round-to-nearest-even, as the inverse-direction companion of fsqrt.
REQ-004 The FSM SHALL have exactly three states: IDLE, MUL and DONE.
REQ-005 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-006 An operand SHALL be accepted on any edge where in_valid=1 and in_ready=1; x SHALL be latched on that edge.
REQ-007 Accepting an operand SHALL move the FSM from IDLE to MUL.
REQ-008 MUL SHALL run a shift-add multiply over the 24-bit significand {1,m}, one multiplier bit per cycle.
REQ-009 MUL SHALL last exactly 24 cycles, counted by a 5-bit counter, and SHALL produce a 48-bit product.
REQ-010 The normalise/round step SHALL fit in the cycle that leaves MUL, so out_valid rises exactly 25 cycles after the accepting edge.
REQ-011 Every input, including special cases, SHALL take the same 25-cycle latency.
REQ-012 Normalisation: if product bit 47 = 1, the fraction SHALL be taken from bits 46:24 and the exponent carry c = 1; otherwise from bits 45:23 with c = 0.
REQ-013 Rounding SHALL use guard, round and sticky bits (round to nearest, ties to even).
REQ-014 A rounding carry out of the fraction SHALL increment the exponent and clear the fraction.
REQ-015 The biased exponent SHALL be ey = 2*ex - 127 + c (+ rounding carry), computed at 10-bit signed width.
REQ-016 If ey >= 255, then y = 0x7F800000 and ovf = 1.
REQ-017 If ey <= 0, then y = 0x00000000 and udf = 1; denormals are never produced.
REQ-018 The sign of y SHALL always be 0.
REQ-019 Input exponent 0 (zero or denormal) SHALL give y = 0x00000000 with ovf = 0 and udf = 0.
REQ-020 Input x = ±inf SHALL give y = 0x7F800000 with ovf = 0.
REQ-021 Input x = NaN SHALL give y = 0x7FC00000 with ovf = 0 and udf = 0.
REQ-022 In DONE, out_valid SHALL be 1, and y, ovf and udf SHALL stay stable until an edge with out_ready = 1.
REQ-023 On that edge the FSM SHALL return to IDLE.
REQ-024 A new operand SHALL NOT be accepted on the cycle the result is consumed; the earliest next accept is the following cycle.
REQ-025 While not in DONE, y, ovf and udf SHALL hold the last result (0 after reset).
REQ-026 out_ready while not in DONE SHALL be ignored.
REQ-027 in_valid outside IDLE SHALL be ignored.
REQ-028 Changes on x after acceptance SHALL NOT affect the result.

Reset
REQ-029 When rstn = 0 at a rising edge, the FSM SHALL go to IDLE, the counter and datapath registers SHALL clear, and the outputs SHALL read in_ready = 1, out_valid = 0, y = 0, ovf = 0 and udf = 0 from the next cycle.
REQ-030 Reset SHALL take priority over any handshake on the same edge.
REQ-031 A reset during MUL or DONE SHALL discard the operation with no output.

Verification
REQ-032 x = 0x40400000 (3.0) -> y = 0x41100000 (9.0), out_valid exactly 25 cycles after accept; x = 0xBFC00000 (-1.5) -> y = 0x40100000.
REQ-033 Rounding: x = 0x3F800001 -> y = 0x3F800002; x = 0x3FB504F3 -> y = 0x3FFFFFFF, or 0x40000000 on rounding carry, and must match the $shortrealtobits reference bit-exactly.
REQ-034 Specials: x = 0x7F000000 -> y = 0x7F800000 with ovf = 1; x = 0x1F800000 -> y = 0 with udf = 1; x = 0x00400000 -> y = 0; x = 0xFF800000 -> y = 0x7F800000; x = 0x7FC00001 -> y = 0x7FC00000.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> y and out_valid stable, in_ready = 0, in_valid pulses ignored; accept occurs 1 cycle after the out_ready handshake.
REQ-036 Reset: assert rstn = 0 at cycle 10 of MUL -> next cycle in_ready = 1 and out_valid = 0; a fresh x = 0x40000000 -> y = 0x40800000.
REQ-037 Sweep: all 2^23 mantissas at ex = 99 and ex = 160 compared bit-exactly against a $shortrealtobits(fx*fx) model.

Source files
------------

// File: rtl/fsquare_iter.sv
// fsquare_iter: iterative single-precision squarer, y = x*x, round-to-nearest-even.
// A 24-cycle shift-add multiply of the significand with itself, then one cycle of
// normalise/round, so every operand (special or not) takes 25 cycles to its result.
// The sign of y is always 0. Results that overflow give +inf with ovf set; results
// whose exponent would be <= 0 are flushed to +0 with udf set. Denormal inputs read as 0.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rstn       synchronous active-low reset
//   in_valid   operand x offered
//   in_ready   unit idle and able to accept an operand
//   x          IEEE-754 single-precision operand
//   out_valid  result y valid (held until out_ready)
//   out_ready  consumer takes the result
//   y          single-precision x*x
//   ovf        result overflowed to +inf
//   udf        result underflowed and was flushed to +0
module fsquare_iter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST_STEP = 5'd24;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [30:0] x_q, x_d;
  logic [47:0] acc_q, acc_d;
  logic [23:0] mpl_q, mpl_d;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  // The square is always non-negative, so the operand sign is never needed.
  logic unused_sign;
  assign unused_sign = x[31];

  logic [7:0]  ex;
  logic [22:0] mx;
  logic [23:0] mcand;
  assign ex    = x_q[30:23];
  assign mx    = x_q[22:0];
  assign mcand = {1'b1, mx};

  // Right-shifting shift-add step: add the multiplicand into the upper half, then
  // shift the whole accumulator (with the carry) down one bit.
  logic [24:0] psum;
  assign psum = {1'b0, acc_q[47:24]} + (mpl_q[0] ? {1'b0, mcand} : 25'd0);

  // Normalise and round the finished 48-bit product.
  logic               c;
  logic [22:0]        frac_pre;
  logic               g, r, s, rnd_up, rc;
  logic [23:0]        frac_r;
  logic signed [9:0]  ey;
  logic [31:0]        res_y;
  logic               res_ovf, res_udf;

  always_comb begin
    c        = acc_q[47];
    frac_pre = c ? acc_q[46:24] : acc_q[45:23];
    g        = c ? acc_q[23] : acc_q[22];
    r        = c ? acc_q[22] : acc_q[21];
    s        = c ? |acc_q[21:0] : |acc_q[20:0];
    rnd_up   = g & (r | s | frac_pre[0]);
    frac_r   = {1'b0, frac_pre} + {23'd0, rnd_up};
    rc       = frac_r[23];
    ey       = $signed({1'b0, ex, 1'b0}) - 10'sd127 + $signed({9'd0, c}) + $signed({9'd0, rc});

    res_y   = 32'h0000_0000;
    res_ovf = 1'b0;
    res_udf = 1'b0;
    if (ex == 8'hFF) begin
      res_y = (mx != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    end else if (ex == 8'h00) begin
      res_y = 32'h0000_0000;
    end else if (ey >= 10'sd255) begin
      res_y   = 32'h7F80_0000;
      res_ovf = 1'b1;
    end else if (ey <= 10'sd0) begin
      res_y   = 32'h0000_0000;
      res_udf = 1'b1;
    end else begin
      res_y = {1'b0, ey[7:0], rc ? 23'd0 : frac_r[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    acc_d   = acc_q;
    mpl_d   = mpl_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x[30:0];
          acc_d   = 48'd0;
          mpl_d   = {1'b1, x[22:0]};
          cnt_d   = 5'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q != LAST_STEP) begin
          acc_d = {psum, acc_q[23:1]};
          mpl_d = {1'b0, mpl_q[23:1]};
          cnt_d = cnt_q + 5'd1;
        end else begin
          y_d     = res_y;
          ovf_d   = res_ovf;
          udf_d   = res_udf;
          cnt_d   = 5'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      x_q     <= 31'd0;
      acc_q   <= 48'd0;
      mpl_q   <= 24'd0;
      y_q     <= 32'd0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_fsquare_iter.sv
// Bench for fsquare_iter: directed vectors plus sampled mantissa sweeps, checked every
// cycle against a double-precision model of x*x rounded back to single precision.
module tb_fsquare_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b1;
  logic        out_ready = 1'b0;
  logic [31:0] x = 32'd0;
  logic        in_ready, out_valid, ovf, udf;
  logic [31:0] y;

  fsquare_iter dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Square in double precision (exact for a 24x24-bit product), then round to
  // single with ties-to-even, overflow to +inf and flush-to-zero. Returns {ovf, udf, y}.
  function automatic logic [33:0] model(input logic [31:0] xv);
    logic [7:0]  e;
    logic [22:0] m, keep;
    logic [63:0] db, pb;
    logic [28:0] rest;
    logic [23:0] mant;
    logic        up;
    real         d, p;
    int          fe;
    e = xv[30:23];
    m = xv[22:0];
    if (e == 8'hFF) return (m == 23'd0) ? {2'b00, 32'h7F800000} : {2'b00, 32'h7FC00000};
    if (e == 8'h00) return 34'd0;
    db   = {1'b0, {3'b000, e} + 11'd896, m, 29'd0};
    d    = $bitstoreal(db);
    p    = d * d;
    pb   = $realtobits(p);
    keep = pb[51:29];
    rest = pb[28:0];
    up   = (rest > 29'h10000000) || ((rest == 29'h10000000) && keep[0]);
    mant = {1'b0, keep} + {23'd0, up};
    fe   = int'(pb[62:52]) - 1023 + 127 + int'(mant[23]);
    if (fe >= 255) return {2'b10, 32'h7F800000};
    if (fe <= 0) return {2'b01, 32'h00000000};
    return {2'b00, 1'b0, fe[7:0], mant[23] ? 23'd0 : mant[22:0]};
  endfunction

  // Reference state: busy from accept until consume, result due 25 edges after accept.
  bit          chk_en = 1'b0;
  bit          have_exp = 1'b0;
  bit          ov_exp;
  int          acc_cyc = 0;
  logic [31:0] exp_y, held_y = 32'd0;
  logic        exp_ovf, exp_udf, held_ovf = 1'b0, held_udf = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      ov_exp = have_exp && (cyc >= acc_cyc + 25);
      check("in_ready", 34'(in_ready), 34'(!have_exp));
      check("out_valid", 34'(out_valid), 34'(ov_exp));
      if (ov_exp) begin
        check("y", 34'(y), 34'(exp_y));
        check("ovf", 34'(ovf), 34'(exp_ovf));
        check("udf", 34'(udf), 34'(exp_udf));
      end else begin
        check("y_held", 34'(y), 34'(held_y));
        check("ovf_held", 34'(ovf), 34'(held_ovf));
        check("udf_held", 34'(udf), 34'(held_udf));
      end
      if (!rstn) begin
        have_exp = 1'b0;
        held_y   = 32'd0;
        held_ovf = 1'b0;
        held_udf = 1'b0;
      end else if (ov_exp && out_ready) begin
        have_exp = 1'b0;
        held_y   = exp_y;
        held_ovf = exp_ovf;
        held_udf = exp_udf;
      end else if (!have_exp && in_valid) begin
        {exp_ovf, exp_udf, exp_y} = model(x);
        have_exp = 1'b1;
        acc_cyc  = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 80) begin
      tick();
      n++;
    end
    check("ready_wait", 34'(in_ready), 34'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("valid_wait", 34'(out_valid), 34'd1);
  endtask

  // One operation; x is scrambled after acceptance, in_valid pulses while result is held.
  task automatic run_op(input logic [31:0] xv, input int hold);
    wait_ready();
    in_valid = 1'b1;
    x = xv;
    tick();
    in_valid = 1'b0;
    x = $urandom;
    wait_valid();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      x = $urandom;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_vec [12];

  initial begin
    // Model pinned to hand-computed values.
    check("model_3.0", model(32'h40400000), {2'b00, 32'h41100000});
    check("model_-1.5", model(32'hBFC00000), {2'b00, 32'h40100000});
    check("model_1ulp", model(32'h3F800001), {2'b00, 32'h3F800002});
    check("model_ovf", model(32'h7F000000), {2'b10, 32'h7F800000});
    check("model_udf", model(32'h1F800000), {2'b01, 32'h00000000});
    check("model_denorm", model(32'h00400000), 34'd0);
    check("model_ninf", model(32'hFF800000), {2'b00, 32'h7F800000});
    check("model_nan", model(32'h7FC00001), {2'b00, 32'h7FC00000});
    check("model_2.0", model(32'h40000000), {2'b00, 32'h40800000});

    // Reset held with in_valid high: no accept.
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rstn = 1'b1;
    tick();

    dir_vec = '{32'h40400000, 32'hBFC00000, 32'h3F800001, 32'h3FB504F3, 32'h7F000000,
                32'h1F800000, 32'h00400000, 32'hFF800000, 32'h7FC00001, 32'h7F7FFFFF,
                32'h80000000, 32'h3F800000};
    for (int i = 0; i < 12; i++) run_op(dir_vec[i], i % 3);

    // Backpressure, then a new operand offered on the consume edge.
    wait_ready();
    in_valid = 1'b1;
    x = 32'h3FC00000;
    tick();
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      x = $urandom;
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 32'h40400000;
    tick();
    out_ready = 1'b0;
    check("rdy_after_consume", 34'(in_ready), 34'd1);
    tick();
    in_valid = 1'b0;
    check("accept_next_cycle", 34'(in_ready), 34'd0);
    wait_valid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of MUL discards the operation.
    wait_ready();
    in_valid = 1'b1;
    x = 32'h40400000;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rst_in_ready", 34'(in_ready), 34'd1);
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_y", 34'(y), 34'd0);
    run_op(32'h40000000, 0);

    // Sampled mantissa sweeps at ex = 99 and ex = 160, including the end points.
    run_op({1'b0, 8'd99, 23'd0}, 0);
    run_op({1'b1, 8'd99, 23'h7FFFFF}, 0);
    run_op({1'b0, 8'd160, 23'd0}, 0);
    run_op({1'b1, 8'd160, 23'h7FFFFF}, 0);
    for (int i = 0; i < 150; i++) run_op({1'($urandom), 8'd99, 23'($urandom)}, 0);
    for (int i = 0; i < 150; i++) run_op({1'($urandom), 8'd160, 23'($urandom)}, 0);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
